// File: rtl/mips_cache_pkg.sv
// Shared types and helpers for the MIPS cache refill / write-through controller.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package mips_cache_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FILL  = 2'd2,
      WRITE = 2'd3
   } cache_ctrl_state_t;

   // Clear the byte offset so every bus and fill address names a whole word.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mips_cache_wbuf.sv
// One-entry posted write buffer: holds address, data and byte enables of a pending write.
// Latency: a push is visible on the outputs (and full_o) the cycle after it is accepted.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module mips_cache_wbuf #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push_i,
   input  logic [ADDR_W-1:0]   push_addr_i,
   input  logic [DATA_W-1:0]   push_data_i,
   input  logic [DATA_W/8-1:0] push_be_i,
   input  logic                pop_i,
   output logic                full_o,
   output logic [ADDR_W-1:0]   addr_o,
   output logic [DATA_W-1:0]   data_o,
   output logic [DATA_W/8-1:0] be_o
);

   logic                full_q, full_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W/8-1:0] be_q, be_d;
   logic                push_ok;

   assign push_ok = push_i & (~full_q | pop_i);

   // Next entry contents: a pop empties the slot, an accepted push refills it.
   always_comb begin
      full_d = full_q;
      addr_d = addr_q;
      data_d = data_q;
      be_d   = be_q;
      if (pop_i) begin
         full_d = 1'b0;
      end
      if (push_ok) begin
         full_d = 1'b1;
         addr_d = push_addr_i;
         data_d = push_data_i;
         be_d   = push_be_i;
      end
   end

   // Entry storage with synchronous reset to an empty, zeroed slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         be_q   <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
         data_q <= data_d;
         be_q   <= be_d;
      end
   end

   assign full_o = full_q;
   assign addr_o = addr_q;
   assign data_o = data_q;
   assign be_o   = be_q;

endmodule

// File: rtl/mips_cache_controller.sv
// Read-miss refill and write-through engine between the cache data array and an Avalon-style bus.
// Latency: read miss 2 cycles + wait states to the fill strobe; write 1 cycle + wait states.
// Backpressure: holds bus requests while mem_waitrequest=1; stalls the CPU via ctrl_stall.
// Build option: define MIPS_CACHE_CTRL_WBUF_EN for a one-entry posted write buffer.
module mips_cache_controller #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic                cpu_read,
   input  logic                cpu_write,
   input  logic [DATA_W-1:0]   cpu_writedata,
   input  logic [DATA_W/8-1:0] cpu_byteenable,
   input  logic                cache_miss,
   output logic                ctrl_stall,
   output logic [DATA_W-1:0]   data_in,
   output logic [ADDR_W-1:0]   data_addr,
   output logic                data_valid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_read,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic [DATA_W/8-1:0] mem_byteenable,
   input  logic                mem_waitrequest,
   input  logic [DATA_W-1:0]   mem_readdata
);

   import mips_cache_pkg::*;

   cache_ctrl_state_t   state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rd_miss;

   assign rd_miss = cpu_read & cache_miss;

`ifdef MIPS_CACHE_CTRL_WBUF_EN
   logic                wb_push, wb_pop, wb_full;
   logic [ADDR_W-1:0]   wb_addr;
   logic [DATA_W-1:0]   wb_data;
   logic [DATA_W/8-1:0] wb_be;

   // Writes are posted from IDLE only when the slot is free; WRITE drains the slot.
   assign wb_push = (state_q == IDLE) & cpu_write & ~wb_full;
   assign wb_pop  = (state_q == WRITE) & ~mem_waitrequest;

   mips_cache_wbuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wbuf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (wb_push),
      .push_addr_i (word_align(cpu_addr)),
      .push_data_i (cpu_writedata),
      .push_be_i   (cpu_byteenable),
      .pop_i       (wb_pop),
      .full_o      (wb_full),
      .addr_o      (wb_addr),
      .data_o      (wb_data),
      .be_o        (wb_be)
   );
`else
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] be_q, be_d;

   // Latched write data and lanes for the blocking write-through.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end
`endif

   // State register plus the latched address and captured read word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic; a write in IDLE always beats a simultaneous read.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
`ifndef MIPS_CACHE_CTRL_WBUF_EN
      wdata_d = wdata_q;
      be_d    = be_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef MIPS_CACHE_CTRL_WBUF_EN
            // A full buffer must drain first so a following read miss sees the new data.
            if (wb_full | cpu_write) begin
               state_d = WRITE;
            end
`else
            if (cpu_write) begin
               state_d = WRITE;
               addr_d  = word_align(cpu_addr);
               wdata_d = cpu_writedata;
               be_d    = cpu_byteenable;
            end
`endif
            else if (rd_miss) begin
               state_d = FETCH;
               addr_d  = word_align(cpu_addr);
            end
         end
         FETCH: begin
            if (!mem_waitrequest) begin
               rdata_d = mem_readdata;
               state_d = FILL;
            end
         end
         FILL: begin
            state_d = IDLE;
         end
         WRITE: begin
            if (!mem_waitrequest) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the current state; the IDLE write stall is combinational.
   always_comb begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_byteenable = '0;
      data_valid     = 1'b0;
      ctrl_stall     = 1'b0;
      mem_address    = addr_q;
      data_in        = rdata_q;
      data_addr      = addr_q;
`ifdef MIPS_CACHE_CTRL_WBUF_EN
      mem_writedata  = wb_data;
`else
      mem_writedata  = wdata_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef MIPS_CACHE_CTRL_WBUF_EN
            ctrl_stall = (cpu_write | rd_miss) & wb_full;
`else
            ctrl_stall = cpu_write;
`endif
         end
         FETCH: begin
            mem_read       = 1'b1;
            mem_byteenable = '1;
            ctrl_stall     = 1'b1;
         end
         FILL: begin
            data_valid = 1'b1;
            ctrl_stall = 1'b1;
         end
         WRITE: begin
            mem_write = 1'b1;
`ifdef MIPS_CACHE_CTRL_WBUF_EN
            // Hits proceed during a drain; only a second write or a read miss waits.
            mem_address    = wb_addr;
            mem_byteenable = wb_be;
            ctrl_stall     = (cpu_write | rd_miss) & wb_full;
`else
            mem_byteenable = be_q;
            ctrl_stall     = 1'b1;
`endif
         end
         default: begin
            ctrl_stall = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/mips_cache_controller.md
# mips_cache_controller

Memory-side refill and write-through engine paired with the cache data array. On a CPU read miss it fetches the word from the Avalon-style memory bus and returns it to the data array on the `data_in`/`data_addr`/`data_valid` fill port. CPU writes go through to memory; the data array updates its own copy on a tag hit. Sits between the CPU-facing cache data array and the memory bus.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: word width; byte-enable width is `DATA_W/8`.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `cpu_addr` in 32: CPU byte address.
- `cpu_read` in 1: CPU read request.
- `cpu_write` in 1: CPU write request.
- `cpu_writedata` in 32: CPU write data.
- `cpu_byteenable` in 4: CPU write byte enables.
- `cache_miss` in 1: data array stall (no tag hit).
- `ctrl_stall` out 1: controller stall toward CPU; the pipeline ORs it with `cache_miss`.
- `data_in` out 32: fill word to the data array.
- `data_addr` out 32: fill address, word aligned.
- `data_valid` out 1: one-cycle fill strobe.
- `mem_address` out 32: memory address, word aligned.
- `mem_read` / `mem_write` out 1: memory requests.
- `mem_writedata` out 32, `mem_byteenable` out 4: memory write data and lanes.
- `mem_waitrequest` in 1: memory not ready.
- `mem_readdata` in 32: valid in the cycle `mem_read` is high and `mem_waitrequest` is low.

## Operation
- States: IDLE, FETCH, FILL, WRITE.
- IDLE transitions:
  - `cpu_write` -> WRITE. Latch `{cpu_addr[31:2],2'b00}`, write data and byte enables.
  - Else `cpu_read & cache_miss` -> FETCH. Latch the word-aligned address.
  - Else stay in IDLE.
  - `cpu_read` and `cpu_write` together is a protocol violation; write wins.
- FETCH:
  - `mem_read`=1, `mem_byteenable`=4'b1111, `mem_address` = latched address; all held stable while `mem_waitrequest`=1.
  - When `mem_waitrequest`=0, capture `mem_readdata` and go to FILL.
- FILL: `data_valid`=1 for exactly one cycle with the captured `data_in` and `data_addr`, then IDLE.
- WRITE: `mem_write`=1 with latched address, data and enables, held while `mem_waitrequest`=1. When `mem_waitrequest`=0, go to IDLE.
- No write-allocate: a write miss does not fetch the word.
- `ctrl_stall` = (IDLE & `cpu_write`) | WRITE | FETCH | FILL. It falls in the cycle the write handshake completes.
- Reset values: state IDLE; `data_valid`, `mem_read`, `mem_write`, `ctrl_stall` = 0; `data_in`, `data_addr`, `mem_address`, `mem_writedata` = 0; `mem_byteenable` = 0.

## Timing
- Read miss timeline, with miss sampled at edge N:
  - `mem_read` high from N+1.
  - With zero wait states, `data_valid` is high at N+2.
  - IDLE at N+3; the data array hits at N+3.
- Read-miss latency: 2 cycles + wait states.
- Write-through latency: 1 cycle + wait states. `ctrl_stall` is combinational in IDLE.
- IDLE ignores `cache_miss` in the cycle after FILL only through state. Because FILL always returns to IDLE, the array is already updated when IDLE samples again, so no spurious refetch occurs.
- Reset mid-transaction: state goes to IDLE and all requests drop at the next edge. The in-flight bus transaction is abandoned; the memory model must tolerate this.

## Configuration
- `MIPS_CACHE_CTRL_WBUF_EN` defined: one-entry posted write buffer.
  - A CPU write in IDLE with the buffer empty is captured with no stall (`ctrl_stall`=0), and the buffer drains via WRITE in the background.
  - A second write while the buffer is full stalls until the drain completes.
  - A read miss while the buffer is full waits for the drain before FETCH, preserving read-after-write ordering.
  - A read hit proceeds during the drain.
- Undefined: behaviour is exactly as in Operation; every write stalls for its full duration.

## Structure
- Package `mips_cache_pkg`: state enum `cache_ctrl_state_t`, `ADDR_W`/`DATA_W` constants, and the word-align helper function.
- Sub-module `mips_cache_wbuf`: one-entry write buffer holding address, data, byte enables and a full flag, with a push/pop interface. It is instantiated only under `MIPS_CACHE_CTRL_WBUF_EN`.

## Test plan
- Read miss, zero wait: `cpu_read`=1, `cache_miss`=1, `cpu_addr`=0x1003, `mem_readdata`=0xDEADBEEF.
  - Expect `mem_address`=0x1000 at N+1.
  - Expect `data_valid`=1, `data_in`=0xDEADBEEF, `data_addr`=0x1000 at N+2, for one cycle only.
- Read miss, 3 wait states: `mem_read` and `mem_address` stay stable for 4 cycles; `data_valid` appears at N+5; `ctrl_stall` stays high throughout.
- Write-through (macro off): `cpu_write`=1, addr 0x2000, data 0x12345678, byteenable 4'b0011, 1 wait state.
  - Expect `mem_write` for 2 cycles with those exact values.
  - Expect `ctrl_stall` high for 3 cycles, and no `data_valid`.
- Simultaneous read and write: WRITE is taken and `mem_read` never asserts.
- Reset asserted during FETCH with waitrequest held at 1: the next cycle has all outputs at reset values; a fresh miss afterwards completes normally.
- Write buffer (macro on): a write immediately followed by a read miss to the same address.
  - Expect `ctrl_stall`=0 on the write.
  - Expect `mem_write` to complete before `mem_read` asserts, and the fill to return the memory model's updated word.
